fc7_rm_ctrl: RTL and testbench

- Sequencer for the fc7 weight RAM, a 2048x32 simple dual-port RAM with 2-cycle read latency, port B always enabled.
- LOAD phase: streams weights from the DDR loader into RAM port A.
- READ phase: replays addresses 0..num_words-1 num_pass times to the fc7 MAC array.
- Read latency and backpressure are absorbed with a credit counter and a small output FIFO.

---
 rtl/fc7_pkg.sv | 23 ++
 rtl/fc7_rm_if.sv | 47 ++++
 rtl/fc7_rm_fifo.sv | 58 +++++
 rtl/fc7_rm_ctrl.sv | 162 ++++++++++++++++
 tb/tb_fc7_rm_ctrl.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fc7_pkg.sv
`default_nettype none
// ============================================================================
// fc7_pkg : shared constants and state encoding for the fc7 weight-RAM sequencer
// Revision : 1.0
// ============================================================================
package fc7_pkg;

    localparam int FC7_ADDR_WIDTH = 11;
    localparam int FC7_DATA_WIDTH = 32;
    localparam int FC7_RD_LATENCY = 2;
    localparam int FC7_FIFO_DEPTH = 4;
    localparam int FC7_PASS_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fc7_rm_if.sv
`default_nettype none
// ============================================================================
// fc7_rm_if : control, load stream, RAM ports and weight stream of fc7_rm_ctrl
// Revision  : 1.0
// ============================================================================
interface fc7_rm_if
    import fc7_pkg::*;
#(
    parameter int ADDR_WIDTH = FC7_ADDR_WIDTH,
    parameter int DATA_WIDTH = FC7_DATA_WIDTH,
    parameter int PASS_WIDTH = FC7_PASS_WIDTH
);
    logic                  start;
    logic                  cfg_load;
    logic [ADDR_WIDTH:0]   cfg_words;
    logic [PASS_WIDTH-1:0] cfg_pass;
    logic                  ld_valid;
    logic                  ld_ready;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ram_wea;
    logic [ADDR_WIDTH-1:0] ram_addra;
    logic [DATA_WIDTH-1:0] ram_dina;
    logic [ADDR_WIDTH-1:0] ram_addrb;
    logic [DATA_WIDTH-1:0] ram_doutb;
    logic                  wt_valid;
    logic                  wt_ready;
    logic [DATA_WIDTH-1:0] wt_data;
    logic                  wt_last;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, cfg_load, cfg_words, cfg_pass,
        input  ld_valid, ld_data, ram_doutb, wt_ready,
        output ld_ready, ram_wea, ram_addra, ram_dina, ram_addrb,
        output wt_valid, wt_data, wt_last, busy, done
    );

    modport slave (
        output start, cfg_load, cfg_words, cfg_pass,
        output ld_valid, ld_data, ram_doutb, wt_ready,
        input  ld_ready, ram_wea, ram_addra, ram_dina, ram_addrb,
        input  wt_valid, wt_data, wt_last, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/fc7_rm_fifo.sv
`default_nettype none
// ============================================================================
// fc7_rm_fifo : small synchronous FIFO with occupancy count; head reads 0 when empty
// Revision    : 1.0
// ============================================================================
module fc7_rm_fifo #(
    parameter int WIDTH     = 33,
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [WIDTH-1:0]     din,
    input  logic                 pop,
    output logic [WIDTH-1:0]     dout,
    output logic [CNT_WIDTH-1:0] count
);
    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_WIDTH'(DEPTH)) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : wr_ptr + PTR_WIDTH'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : rd_ptr + PTR_WIDTH'(1);
            end
            count <= count + CNT_WIDTH'(do_push) - CNT_WIDTH'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    assign dout = (count != '0) ? mem[rd_ptr] : '0;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (count == CNT_WIDTH'(DEPTH)) && !pop));

endmodule
`default_nettype wire

// File: rtl/fc7_rm_ctrl.sv
`default_nettype none
// ============================================================================
// fc7_rm_ctrl : loads fc7 weights into RAM, then replays them num_pass times
// Revision    : 1.0
// ============================================================================
module fc7_rm_ctrl
    import fc7_pkg::*;
#(
    parameter int ADDR_WIDTH = FC7_ADDR_WIDTH,
    parameter int DATA_WIDTH = FC7_DATA_WIDTH,
    parameter int RD_LATENCY = FC7_RD_LATENCY,
    parameter int FIFO_DEPTH = FC7_FIFO_DEPTH,
    parameter int PASS_WIDTH = FC7_PASS_WIDTH
) (
    input  logic     clk,
    input  logic     rst,
    fc7_rm_if.master bus
);
    localparam int                    CNT_WIDTH = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH:0]   WORD_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [PASS_WIDTH-1:0] PASS_ONE  = {{(PASS_WIDTH-1){1'b0}}, 1'b1};

    state_t                state;
    logic [ADDR_WIDTH:0]   words;
    logic [ADDR_WIDTH:0]   words_m1;
    logic [PASS_WIDTH-1:0] passes;
    logic [PASS_WIDTH-1:0] pass_cnt;
    logic [ADDR_WIDTH:0]   wr_cnt;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] addrb;
    logic [RD_LATENCY-1:0] vld_sr;
    logic [RD_LATENCY-1:0] lst_sr;
    logic [CNT_WIDTH-1:0]  inflight;
    logic [CNT_WIDTH-1:0]  fifo_cnt;
    logic [DATA_WIDTH:0]   fifo_dout;
    logic                  beat;
    logic                  issue;
    logic                  last_addr;
    logic                  last_pass;
    logic                  tail_vld;
    logic                  pop;
    logic                  drain_empty;

    assign words_m1  = words - WORD_ONE;
    assign beat      = (state == ST_LOAD) && bus.ld_valid;
    assign last_addr = ({1'b0, rd_addr} == words_m1);
    assign last_pass = (pass_cnt == passes - PASS_ONE);
    assign tail_vld  = vld_sr[RD_LATENCY-1];
    assign pop       = bus.wt_valid && bus.wt_ready;

    // Credit: every issued read owns a FIFO slot until it is popped; no pop bypass.
    assign issue = (state == ST_READ) &&
                   (({1'b0, inflight} + {1'b0, fifo_cnt}) < (CNT_WIDTH + 1)'(FIFO_DEPTH));

    // Look one cycle ahead so done follows the final pop by exactly one cycle.
    assign drain_empty = (inflight == '0) &&
                         ((fifo_cnt == '0) || ((fifo_cnt == CNT_WIDTH'(1)) && pop));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            words    <= '0;
            passes   <= '0;
            pass_cnt <= '0;
            wr_cnt   <= '0;
            rd_addr  <= '0;
            addrb    <= '0;
            vld_sr   <= '0;
            lst_sr   <= '0;
            inflight <= '0;
        end else begin
            vld_sr[0] <= issue;
            lst_sr[0] <= issue && last_addr;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                lst_sr[i] <= lst_sr[i-1];
            end
            inflight <= inflight + CNT_WIDTH'(issue) - CNT_WIDTH'(tail_vld);

            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        words    <= bus.cfg_words;
                        passes   <= (bus.cfg_pass == '0) ? PASS_ONE : bus.cfg_pass;
                        pass_cnt <= '0;
                        wr_cnt   <= '0;
                        rd_addr  <= '0;
                        if (bus.cfg_words == '0) begin
                            state <= ST_DONE;
                        end else if (bus.cfg_load) begin
                            state <= ST_LOAD;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                ST_LOAD: begin
                    if (beat) begin
                        if (wr_cnt == words_m1) begin
                            wr_cnt <= '0;
                            state  <= ST_READ;
                        end else begin
                            wr_cnt <= wr_cnt + WORD_ONE;
                        end
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        addrb <= rd_addr;
                        if (last_addr) begin
                            rd_addr  <= '0;
                            pass_cnt <= pass_cnt + PASS_ONE;
                            if (last_pass) begin
                                state <= ST_DRAIN;
                            end
                        end else begin
                            rd_addr <= rd_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_empty) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    fc7_rm_fifo #(
        .WIDTH     (DATA_WIDTH + 1),
        .DEPTH     (FIFO_DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tail_vld),
        .din   ({bus.ram_doutb, lst_sr[RD_LATENCY-1]}),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_cnt)
    );

    assign bus.ld_ready  = (state == ST_LOAD);
    assign bus.ram_wea   = beat;
    assign bus.ram_addra = wr_cnt[ADDR_WIDTH-1:0];
    assign bus.ram_dina  = beat ? bus.ld_data : '0;
    assign bus.ram_addrb = addrb;
    assign bus.wt_valid  = (fifo_cnt != '0);
    assign bus.wt_data   = fifo_dout[DATA_WIDTH:1];
    assign bus.wt_last   = fifo_dout[0];
    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = (state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_fc7_rm_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fc7_rm_ctrl : directed self-checking bench for fc7_rm_ctrl with a RAM model
// Revision       : 1.0
// ============================================================================
module tb_fc7_rm_ctrl;
    import fc7_pkg::*;

    localparam int AW = 11;
    localparam int DW = 32;
    localparam int PW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fc7_rm_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PASS_WIDTH(PW)) bus ();

    fc7_rm_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RD_LATENCY (2),
        .FIFO_DEPTH (4),
        .PASS_WIDTH (PW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM model: ram_addrb is the first latency stage, this register the second.
    logic [DW-1:0] mem [0:2047];
    logic [DW-1:0] doutb_q;
    always @(posedge clk) begin
        if (bus.ram_wea) mem[bus.ram_addra] <= bus.ram_dina;
        doutb_q <= mem[bus.ram_addrb];
    end
    assign bus.ram_doutb = doutb_q;

    typedef struct {logic [DW-1:0] data; logic last; int cyc;} out_t;
    typedef struct {logic [AW-1:0] addr; logic [DW-1:0] data;} wr_t;
    out_t out_q[$];
    wr_t  wr_q[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int done_cnt, done_cyc, start_cyc, ldr_cnt, issue_cnt;
    int first_issue, first_valid, max_fifo, stall_err;
    int ready_mode = 0;
    logic          stalled = 1'b0;
    logic [DW-1:0] st_data;
    logic          st_last;

    function automatic logic [DW-1:0] pat(input int a);
        return 32'hA500_0000 + (a * 32'h0001_0003);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        out_t o;
        wr_t  w;
        if (!rst) begin
            if (bus.wt_valid && bus.wt_ready) begin
                o.data = bus.wt_data; o.last = bus.wt_last; o.cyc = cyc;
                out_q.push_back(o);
            end
            if (bus.ram_wea) begin
                w.addr = bus.ram_addra; w.data = bus.ram_dina;
                wr_q.push_back(w);
            end
            if (bus.done) begin done_cnt++; done_cyc = cyc; end
            if (bus.start && !bus.busy) start_cyc = cyc;
            if (bus.ld_ready) ldr_cnt++;
            if (dut.issue) begin
                if (issue_cnt == 0) first_issue = cyc;
                issue_cnt++;
            end
            if (bus.wt_valid && first_valid < 0) first_valid = cyc;
            if (int'(dut.fifo_cnt) > max_fifo) max_fifo = int'(dut.fifo_cnt);
            if (stalled && !(bus.wt_valid && bus.wt_data == st_data && bus.wt_last == st_last))
                stall_err++;
            stalled = bus.wt_valid && !bus.wt_ready;
            st_data = bus.wt_data;
            st_last = bus.wt_last;
        end else begin
            stalled = 1'b0;
        end
    end

    // wt_ready: mode 0 always ready, 1 pattern 1,0,0 repeating, 2 never ready
    initial begin
        bus.wt_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                1:       bus.wt_ready = (cyc % 3 == 0);
                2:       bus.wt_ready = 1'b0;
                default: bus.wt_ready = 1'b1;
            endcase
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_mon();
        out_q.delete(); wr_q.delete();
        done_cnt = 0; done_cyc = -1; start_cyc = -1; ldr_cnt = 0; issue_cnt = 0;
        first_issue = -1; first_valid = -1; max_fifo = 0; stall_err = 0;
    endtask

    task automatic pulse_start(input logic load, input logic [AW:0] words, input logic [PW-1:0] pass);
        @(posedge clk); #1;
        bus.cfg_load = load; bus.cfg_words = words; bus.cfg_pass = pass; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt > 0) begin ok = 1'b1; break; end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({bus.busy, bus.done, bus.ld_ready, bus.ram_wea, bus.wt_valid, bus.wt_last} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {bus.busy, bus.done, bus.ld_ready, bus.ram_wea, bus.wt_valid, bus.wt_last});
        end
        vectors++;
        if ({bus.ram_addrb, bus.ram_addra, bus.wt_data, bus.ram_dina} !== '0) begin
            miscompares++;
            $display("FAIL reset_buses: addrb=%h addra=%h wt_data=%h dina=%h expected all 0",
                     bus.ram_addrb, bus.ram_addra, bus.wt_data, bus.ram_dina);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle_busy: got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_load_read();
        bit ok;
        int k;
        clear_mon();
        ready_mode = 0;
        pulse_start(1'b1, 12'd8, 8'd2);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin bus.ld_valid = 1'b0; @(posedge clk); #1; end
            bus.ld_valid = 1'b1;
            bus.ld_data  = 32'h100 + i;
            k = 0;
            @(negedge clk);
            while (!bus.ld_ready && k < 20) begin @(negedge clk); k++; end
            @(posedge clk); #1;
        end
        bus.ld_valid = 1'b0;
        wait_done(200, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL load_read_done: timeout, done not seen"); end
        vectors++;
        if (wr_q.size() != 8) begin
            miscompares++; $display("FAIL load_writes: got %0d writes expected 8", wr_q.size());
        end
        for (int i = 0; i < wr_q.size(); i++) begin
            vectors++;
            if (wr_q[i].addr !== AW'(i) || wr_q[i].data !== 32'h100 + i) begin
                miscompares++;
                $display("FAIL load_write[%0d]: got addr %0d data %h expected addr %0d data %h",
                         i, wr_q[i].addr, wr_q[i].data, i, 32'h100 + i);
            end
        end
        vectors++;
        if (out_q.size() != 16) begin
            miscompares++; $display("FAIL load_read_count: got %0d words expected 16", out_q.size());
        end
        for (int i = 0; i < out_q.size(); i++) begin
            vectors++;
            if (out_q[i].data !== 32'h100 + (i % 8) || out_q[i].last !== (i % 8 == 7)) begin
                miscompares++;
                $display("FAIL load_read_word[%0d]: got %h last %b expected %h last %b",
                         i, out_q[i].data, out_q[i].last, 32'h100 + (i % 8), (i % 8 == 7));
            end
        end
        if (out_q.size() > 0) begin
            vectors++;
            if (done_cyc != out_q[out_q.size()-1].cyc + 1) begin
                miscompares++;
                $display("FAIL done_after_pop: done at cycle %0d expected %0d",
                         done_cyc, out_q[out_q.size()-1].cyc + 1);
            end
        end
        vectors++;
        if (first_valid - first_issue != 3) begin
            miscompares++;
            $display("FAIL first_word_latency: got %0d expected 3", first_valid - first_issue);
        end
        vectors++;
        if (done_cnt != 1 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL load_read_end: done pulses %0d busy %b expected 1 and 0", done_cnt, bus.busy);
        end
    endtask

    task automatic test_zero_words();
        bit ok;
        clear_mon();
        bus.ld_valid = 1'b1;
        bus.ld_data  = 32'hDEAD_BEEF;
        pulse_start(1'b1, 12'd0, 8'd3);
        wait_done(10, ok);
        bus.ld_valid = 1'b0;
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL zero_done: timeout, done not seen"); end
        vectors++;
        if (done_cyc != start_cyc + 1) begin
            miscompares++;
            $display("FAIL zero_done_cycle: got %0d expected %0d", done_cyc, start_cyc + 1);
        end
        vectors++;
        if (wr_q.size() != 0 || issue_cnt != 0 || ldr_cnt != 0) begin
            miscompares++;
            $display("FAIL zero_no_access: writes %0d reads %0d ld_ready cycles %0d expected 0 0 0",
                     wr_q.size(), issue_cnt, ldr_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        for (int a = 0; a < 2048; a++) mem[a] = pat(a);
        clear_mon();
        ready_mode = 1;
        pulse_start(1'b0, 12'd16, 8'd0);
        wait_done(400, ok);
        ready_mode = 0;
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL bp_done: timeout, done not seen"); end
        vectors++;
        if (out_q.size() != 16) begin
            miscompares++; $display("FAIL bp_count: got %0d words expected 16", out_q.size());
        end
        for (int i = 0; i < out_q.size(); i++) begin
            vectors++;
            if (out_q[i].data !== pat(i) || out_q[i].last !== (i == 15)) begin
                miscompares++;
                $display("FAIL bp_word[%0d]: got %h last %b expected %h last %b",
                         i, out_q[i].data, out_q[i].last, pat(i), (i == 15));
            end
        end
        vectors++;
        if (stall_err != 0) begin
            miscompares++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_err);
        end
        vectors++;
        if (max_fifo > 4) begin
            miscompares++; $display("FAIL bp_fifo_max: got %0d expected <= 4", max_fifo);
        end
    endtask

    task automatic test_full_depth();
        bit ok;
        int lasts;
        clear_mon();
        ready_mode = 0;
        pulse_start(1'b0, 12'd2048, 8'd1);
        wait_done(2500, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL full_done: timeout, done not seen"); end
        vectors++;
        if (out_q.size() != 2048) begin
            miscompares++; $display("FAIL full_count: got %0d words expected 2048", out_q.size());
        end
        lasts = 0;
        for (int i = 0; i < out_q.size(); i++) begin
            if (out_q[i].last) lasts++;
            vectors++;
            if (out_q[i].data !== pat(i) || out_q[i].last !== (i == 2047) ||
                out_q[i].cyc != out_q[0].cyc + i) begin
                miscompares++;
                $display("FAIL full_word[%0d]: got %h last %b cycle %0d expected %h last %b cycle %0d",
                         i, out_q[i].data, out_q[i].last, out_q[i].cyc, pat(i), (i == 2047),
                         out_q[0].cyc + i);
            end
        end
        vectors++;
        if (lasts != 1) begin
            miscompares++; $display("FAIL full_lasts: got %0d expected 1", lasts);
        end
        vectors++;
        if (first_valid - first_issue != 3) begin
            miscompares++;
            $display("FAIL full_latency: got %0d expected 3", first_valid - first_issue);
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        clear_mon();
        ready_mode = 2;
        pulse_start(1'b0, 12'd16, 8'd1);
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (issue_cnt != 3) begin
            miscompares++; $display("FAIL midrst_issued: got %0d expected 3", issue_cnt);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus.busy, bus.done, bus.wt_valid, bus.wt_last, bus.ld_ready, bus.ram_wea} !== 6'b0 ||
            bus.ram_addrb !== '0 || bus.wt_data !== '0) begin
            miscompares++;
            $display("FAIL midrst_outputs: flags %b addrb %h wt_data %h expected all 0",
                     {bus.busy, bus.done, bus.wt_valid, bus.wt_last, bus.ld_ready, bus.ram_wea},
                     bus.ram_addrb, bus.wt_data);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ready_mode = 0;
        repeat (2) @(posedge clk);
        vectors++;
        if (done_cnt != 0) begin
            miscompares++; $display("FAIL midrst_no_done: got %0d done pulses expected 0", done_cnt);
        end
        clear_mon();
        pulse_start(1'b0, 12'd8, 8'd1);
        wait_done(100, ok);
        vectors++;
        if (!ok || out_q.size() != 8) begin
            miscompares++;
            $display("FAIL midrst_rerun: done %b words %0d expected 1 and 8", ok, out_q.size());
        end
        for (int i = 0; i < out_q.size(); i++) begin
            vectors++;
            if (out_q[i].data !== pat(i) || out_q[i].last !== (i == 7)) begin
                miscompares++;
                $display("FAIL midrst_word[%0d]: got %h last %b expected %h last %b",
                         i, out_q[i].data, out_q[i].last, pat(i), (i == 7));
            end
        end
    endtask

    task automatic test_ignored_start();
        bit ok;
        clear_mon();
        ready_mode = 0;
        pulse_start(1'b0, 12'd16, 8'd2);
        repeat (4) @(posedge clk);
        #1;
        bus.cfg_load = 1'b1; bus.cfg_words = 12'd3; bus.cfg_pass = 8'd1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(300, ok);
        vectors++;
        if (!ok || out_q.size() != 32) begin
            miscompares++;
            $display("FAIL ign_count: done %b words %0d expected 1 and 32", ok, out_q.size());
        end
        for (int i = 0; i < out_q.size(); i++) begin
            vectors++;
            if (out_q[i].data !== pat(i % 16) || out_q[i].last !== (i % 16 == 15)) begin
                miscompares++;
                $display("FAIL ign_word[%0d]: got %h last %b expected %h last %b",
                         i, out_q[i].data, out_q[i].last, pat(i % 16), (i % 16 == 15));
            end
        end
        vectors++;
        if (ldr_cnt != 0 || done_cnt != 1) begin
            miscompares++;
            $display("FAIL ign_state: ld_ready cycles %0d done pulses %0d expected 0 and 1",
                     ldr_cnt, done_cnt);
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.cfg_load = 1'b0; bus.cfg_words = '0; bus.cfg_pass = '0;
        bus.ld_valid = 1'b0; bus.ld_data = '0;
        clear_mon();
        test_reset();
        test_load_read();
        test_zero_words();
        test_backpressure();
        test_full_depth();
        test_mid_reset();
        test_ignored_start();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
